// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Hardware call/return stack that feeds the program counter's stk0 input.
// A call pushes the return address (PC+1); a return pops, and the PC loads
// stk0 on the same clock edge that the pop takes effect. call and ret both
// high together replace the top entry, which is how a tail call is handled.
//
// Optional build macro:
//   RAS_WRAP_EN - when defined, a push while full overwrites the oldest
//                 entry. sp advances modulo DEPTH, depth_cnt saturates at
//                 DEPTH, and ovf_err is still raised as a warning. When it
//                 is undefined, a push while full is dropped and raises
//                 ovf_err.
//
// Parameters:
//   AW     address width (matches the PC width)
//   DEPTH  number of entries (power of two, 2..64)
//   PTRW   pointer width; the occupancy counter is PTRW+1 bits
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   call       push request (one cycle per call instruction)
//   ret        pop request (same strobe the PC uses to select stk0)
//   push_addr  return address to push
//   err_clr    synchronous clear of the sticky error flags
//   stk0       current top-of-stack entry, combinational from storage
//   depth_cnt  number of valid entries, 0..DEPTH
//   empty      depth_cnt == 0
//   full       depth_cnt == DEPTH
//   ovf_err    sticky: push attempted while full
//   unf_err    sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 8,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            call,
    input  logic            ret,
    input  logic [AW-1:0]   push_addr,
    input  logic            err_clr,
    output logic [AW-1:0]   stk0,
    output logic [PTRW:0]   depth_cnt,
    output logic            empty,
    output logic            full,
    output logic            ovf_err,
    output logic            unf_err
);

    localparam logic [PTRW:0]   DEPTH_C = (PTRW + 1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE = (PTRW + 1)'(1);
    localparam logic [PTRW:0]   CNT_ZERO = (PTRW + 1)'(0);
    localparam logic [PTRW-1:0] SP_ONE  = PTRW'(1);
    localparam logic [PTRW-1:0] SP_ZERO = PTRW'(0);

    // Pointer, occupancy and flag state
    logic [PTRW-1:0] sp_r;
    logic [PTRW:0]   depth_r;
    logic            empty_r;
    logic            full_r;
    logic            ovf_r;
    logic            unf_r;

    // Entry 0 is reset so the read path never sees an unwritten slot at
    // the bottom; the remaining entries are plain storage without reset.
    logic [AW-1:0]   mem0_r;
    logic [AW-1:0]   mem_r [1:DEPTH-1];

    // Next-state and write-port signals
    logic [PTRW-1:0] sp_nxt_s;
    logic [PTRW:0]   depth_nxt_s;
    logic            wr_en_s;
    logic [PTRW-1:0] wr_idx_s;
    logic [AW-1:0]   wr_data_s;
    logic            ovf_set_s;
    logic            unf_set_s;
    logic            ovf_nxt_s;
    logic            unf_nxt_s;
    logic [PTRW-1:0] rd_idx_s;

    // Decode {call, ret} into the storage write, pointer move and error sets
    always_comb begin
        sp_nxt_s    = sp_r;
        depth_nxt_s = depth_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = sp_r;
        wr_data_s   = push_addr;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        case ({call, ret})
            2'b10: begin
                if (!full_r) begin
                    wr_en_s     = 1'b1;
                    sp_nxt_s    = sp_r + SP_ONE;
                    depth_nxt_s = depth_r + CNT_ONE;
                end else begin
                    ovf_set_s   = 1'b1;
`ifdef RAS_WRAP_EN
                    // When full, sp already points at the oldest entry, so
                    // writing there drops it; depth_cnt stays at DEPTH.
                    wr_en_s     = 1'b1;
                    sp_nxt_s    = sp_r + SP_ONE;
`endif
                end
            end
            2'b01: begin
                if (!empty_r) begin
                    sp_nxt_s    = sp_r - SP_ONE;
                    depth_nxt_s = depth_r - CNT_ONE;
                end else begin
                    unf_set_s   = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_r) begin
                    // Tail call: overwrite the top entry in place.
                    wr_en_s     = 1'b1;
                    wr_idx_s    = sp_r - SP_ONE;
                end else begin
                    // Nothing to replace: behave as a plain push.
                    wr_en_s     = 1'b1;
                    sp_nxt_s    = sp_r + SP_ONE;
                    depth_nxt_s = depth_r + CNT_ONE;
                end
            end
            default: begin
                wr_en_s     = 1'b0;
            end
        endcase
    end

    // A new error in the same cycle as err_clr takes priority over the clear
    always_comb begin
        ovf_nxt_s = ovf_set_s | (ovf_r & ~err_clr);
        unf_nxt_s = unf_set_s | (unf_r & ~err_clr);
    end

    // Pointer, occupancy, status and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r    <= SP_ZERO;
            depth_r <= CNT_ZERO;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            sp_r    <= sp_nxt_s;
            depth_r <= depth_nxt_s;
            empty_r <= (depth_nxt_s == CNT_ZERO);
            full_r  <= (depth_nxt_s == DEPTH_C);
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    // Bottom entry, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_r <= {AW{1'b0}};
        end else if (wr_en_s && (wr_idx_s == SP_ZERO)) begin
            mem0_r <= wr_data_s;
        end
    end

    // Upper entries, no reset; only ever read after being written
    always_ff @(posedge clk) begin
        if (wr_en_s && (wr_idx_s != SP_ZERO)) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Top-of-stack read; forced to zero when empty so stale data never leaks
    always_comb begin
        rd_idx_s = sp_r - SP_ONE;
        if (empty_r) begin
            stk0 = {AW{1'b0}};
        end else if (rd_idx_s == SP_ZERO) begin
            stk0 = mem0_r;
        end else begin
            stk0 = mem_r[rd_idx_s];
        end
    end

    // Output mapping of the registered status
    always_comb begin
        depth_cnt = depth_r;
        empty     = empty_r;
        full      = full_r;
        ovf_err   = ovf_r;
        unf_err   = unf_r;
    end

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

    logic        clk;
    logic        rst_n;
    logic        call;
    logic        ret;
    logic [11:0] push_addr;
    logic        err_clr;
    logic [11:0] stk0;
    logic [3:0]  depth_cnt;
    logic        empty;
    logic        full;
    logic        ovf_err;
    logic        unf_err;

    int passed;
    int total;

    return_addr_stack #(.AW(12), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call      (call),
        .ret       (ret),
        .push_addr (push_addr),
        .err_clr   (err_clr),
        .stk0      (stk0),
        .depth_cnt (depth_cnt),
        .empty     (empty),
        .full      (full),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        call;
        logic        ret;
        logic        clr;
        logic [11:0] addr;
        logic [11:0] e_stk;
        logic [3:0]  e_dep;
        logic        e_emp;
        logic        e_full;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input int c, input int r, input int clr, input int addr,
                        input int stk, input int dep, input int emp, input int fl,
                        input int ovf, input int unf);
        vec_t v;
        v.call   = (c != 0);
        v.ret    = (r != 0);
        v.clr    = (clr != 0);
        v.addr   = 12'(addr);
        v.e_stk  = 12'(stk);
        v.e_dep  = 4'(dep);
        v.e_emp  = (emp != 0);
        v.e_full = (fl != 0);
        v.e_ovf  = (ovf != 0);
        v.e_unf  = (unf != 0);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [11:0] e_stk, input logic [3:0] e_dep,
                             input logic e_emp, input logic e_full, input logic e_ovf,
                             input logic e_unf);
        check("stk0", idx, 32'(stk0), 32'(e_stk));
        check("depth_cnt", idx, 32'(depth_cnt), 32'(e_dep));
        check("empty", idx, 32'(empty), 32'(e_emp));
        check("full", idx, 32'(full), 32'(e_full));
        check("ovf_err", idx, 32'(ovf_err), 32'(e_ovf));
        check("unf_err", idx, 32'(unf_err), 32'(e_unf));
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
        push_addr = 12'h000;
        err_clr   = 1'b0;

        // ---- vector table: c r clr addr | stk dep emp full ovf unf ----
        addv(1, 0, 0, 'h010, 'h010, 1, 0, 0, 0, 0);
        addv(1, 0, 0, 'h020, 'h020, 2, 0, 0, 0, 0);
        addv(1, 0, 0, 'h030, 'h030, 3, 0, 0, 0, 0);
        addv(0, 1, 0, 'h000, 'h020, 2, 0, 0, 0, 0);
        addv(0, 1, 0, 'h000, 'h010, 1, 0, 0, 0, 0);
        addv(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            addv(1, 0, 0, 'h100 + i, 'h100 + i, i + 1, 0, (i == 7) ? 1 : 0, 0, 0);
        end
`ifdef RAS_WRAP_EN
        addv(1, 0, 0, 'h1FF, 'h1FF, 8, 0, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            addv(0, 1, 0, 'h000, (k < 8) ? ('h108 - k) : 0, 8 - k, (k == 8) ? 1 : 0, 0, 1, 0);
        end
`else
        addv(1, 0, 0, 'h1FF, 'h107, 8, 0, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            addv(0, 1, 0, 'h000, (k < 8) ? ('h107 - k) : 0, 8 - k, (k == 8) ? 1 : 0, 0, 1, 0);
        end
`endif
        addv(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);   // clear ovf
        addv(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 1);   // pop empty
        addv(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);   // clear unf
        addv(0, 1, 1, 'h000, 'h000, 0, 1, 0, 0, 1);   // set wins over clear
        addv(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);
        addv(1, 0, 0, 'h050, 'h050, 1, 0, 0, 0, 0);
        addv(1, 1, 0, 'h0A0, 'h0A0, 1, 0, 0, 0, 0);   // replace
        addv(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 0);
        addv(1, 1, 0, 'h0B0, 'h0B0, 1, 0, 0, 0, 0);   // replace while empty = push
        addv(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 0);

        // ---- reset state ----
        #12;
        check_all(-1, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table loop ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            call      = vecs[i].call;
            ret       = vecs[i].ret;
            err_clr   = vecs[i].clr;
            push_addr = vecs[i].addr;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_stk, vecs[i].e_dep, vecs[i].e_emp,
                      vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // ---- ret-cycle visibility: stk0 valid while ret is high ----
        @(negedge clk);
        call = 1'b1; ret = 1'b0; err_clr = 1'b0; push_addr = 12'h077;
        @(negedge clk);
        call = 1'b0; ret = 1'b1;
        #1;
        check("stk0_in_ret_cycle", 100, 32'(stk0), 32'h077);
        @(posedge clk);
        #1;
        check("empty_after_ret", 100, 32'(empty), 32'd1);

        // ---- async reset in the middle of a push ----
        @(negedge clk);
        ret = 1'b0; call = 1'b1; push_addr = 12'h011;
        @(negedge clk);
        push_addr = 12'h022;
        @(negedge clk);
        push_addr = 12'h033;
        check("pre_reset_depth", 200, 32'(depth_cnt), 32'd2);
        check("pre_reset_stk0", 200, 32'(stk0), 32'h022);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(201, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(202, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        call  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all(203, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        call = 1'b1; push_addr = 12'h044;
        @(posedge clk);
        #1;
        check_all(204, 12'h044, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        call = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
